// File: rtl/sa2_conv_sched.sv
// sa2_conv_sched: round-robin scheduler that shares one 2x2 systolic convolution
// array between two tile requesters and returns tagged results.
// Optional build macro: SA2_SCHED_WDT_EN adds a RUN watchdog of TIMEOUT cycles.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. Requesters hold req_valid/operands until req_ready; the response side
// holds rsp_valid/rsp_id/rsp_c/rsp_err stable until rsp_ready. req_ready depends
// combinationally on req_valid; no other output depends combinationally on an input.
module sa2_conv_sched #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [16*DATA_W-1:0] req_a0,
  input  logic [16*DATA_W-1:0] req_a1,
  input  logic [9*DATA_W-1:0]  req_b0,
  input  logic [9*DATA_W-1:0]  req_b1,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [4*DATA_W-1:0] rsp_c,
  output logic                rsp_err,
  output logic                active_sa2,
  output logic [16*DATA_W-1:0] sa_a,
  output logic [9*DATA_W-1:0]  sa_b,
  input  logic                done_sa2,
  input  logic [4*DATA_W-1:0] sa_c,
  output logic                busy
);

  localparam int A_W = 16 * DATA_W;
  localparam int B_W = 9 * DATA_W;
  localparam int C_W = 4 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           owner_q, owner_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [C_W-1:0] c_q, c_d;
  logic           active_q, active_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           busy_q, busy_d;
  logic           grant_valid;
  logic           grant;

`ifdef SA2_SCHED_WDT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign rsp_err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign rsp_err = 1'b0;
`endif

  // Round-robin pick: a lone requester wins, on contention the one not served last wins
  always_comb begin
    grant_valid = |req_valid;
    if (req_valid == 2'b11) grant = ~last_q;
    else                    grant = req_valid[1];
  end

  // Ready only in IDLE; gated by rst so it reads 0 while reset is held
  assign req_ready = (rst && state_q == IDLE && grant_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign active_sa2 = active_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = busy_q;
  assign rsp_id     = owner_q;
  assign rsp_c      = c_q;
  assign sa_a       = a_q;
  assign sa_b       = b_q;

  // Next-state and datapath latching for the IDLE -> RUN -> RESP cycle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
`ifdef SA2_SCHED_WDT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = RUN;
          a_d     = grant ? req_a1 : req_a0;
          b_d     = grant ? req_b1 : req_b0;
          owner_d = grant;
          last_d  = grant;
`ifdef SA2_SCHED_WDT_EN
          cnt_d   = '0;
`endif
        end
      end
      RUN: begin
        // done_sa2 takes priority over a simultaneous watchdog expiry
        if (done_sa2) begin
          c_d     = sa_c;
          state_d = RESP;
`ifdef SA2_SCHED_WDT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    active_d    = (state_d == RUN);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any in-flight tile
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      active_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SA2_SCHED_WDT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      active_q    <= active_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifdef SA2_SCHED_WDT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sa2_conv_sched.sv
// tb_sa2_conv_sched: directed bench for sa2_conv_sched with a behavioural
// convolution stub standing in for the systolic array.
// Watchdog cases run only when SA2_SCHED_WDT_EN is defined.
module tb_sa2_conv_sched;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [127:0] req_a0 = '0, req_a1 = '0;
  logic [71:0]  req_b0 = '0, req_b1 = '0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
  logic [31:0]  rsp_c;
  logic         active_sa2, busy;
  logic [127:0] sa_a;
  logic [71:0]  sa_b;
  logic         done_sa2 = 1'b0;
  logic [31:0]  sa_c = '0;

  sa2_conv_sched #(.DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .active_sa2(active_sa2), .sa_a(sa_a), .sa_b(sa_b),
    .done_sa2(done_sa2), .sa_c(sa_c), .busy(busy)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // 2x2 result of a 4x4 tile convolved with a 3x3 kernel (kernel flipped), mod 256
  function automatic logic [31:0] conv(input logic [127:0] a, input logic [71:0] b);
    logic [31:0] r;
    int s;
    r = '0;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(a[((y + i) * 4 + (x + j)) * 8 +: 8]) * int'(b[((2 - i) * 3 + (2 - j)) * 8 +: 8]);
        r[(y * 2 + x) * 8 +: 8] = s[7:0];
      end
    return r;
  endfunction

  // ---------------- array stub ----------------
  int stub_len   = 5;   // done on this RUN cycle; 0 = never
  bit stray_done = 1'b0;
  int sa_cnt     = 0;
  always @(posedge clk) begin
    #2;
    if (active_sa2) begin
      sa_cnt++;
      done_sa2 = (stub_len != 0) && (sa_cnt == stub_len);
    end else begin
      sa_cnt   = 0;
      done_sa2 = stray_done;
    end
    sa_c = (done_sa2 && active_sa2) ? conv(sa_a, sa_b) : $urandom();
  end

  // ---------------- model, scoreboard, monitor ----------------
  int           m_phase = 0;   // 0 idle, 1 running, 2 responding
  logic         m_last = 1'b1, m_owner = 1'b0, m_err = 1'b0;
  logic [127:0] m_a = '0;
  logic [71:0]  m_b = '0;
  logic [31:0]  m_c = '0;
  int           m_run = 0;
  logic [33:0]  exp_q[$];      // {id, err, c}
  logic [33:0]  rsp_log[$];
  logic         grant_log[$];
  int           run_len_q[$], gap_q[$];
  int           cyc = 0, act_run = 0, low_cnt = 0, last_req_hs = 0, last_rsp_hs = 0;
  bit           had_run = 1'b0;

  always @(negedge clk) begin : compare
    logic       g;
    logic [1:0] e_rr;
    logic [33:0] got;
    cyc++;
    if (req_valid == 2'b11) g = !m_last;
    else                    g = req_valid[1];
    e_rr = 2'b00;
    if (rst && m_phase == 0 && req_valid != 2'b00) e_rr = g ? 2'b10 : 2'b01;
    check("req_ready", req_ready, e_rr);
    check("active_sa2", active_sa2, rst && m_phase == 1);
    check("rsp_valid", rsp_valid, rst && m_phase == 2);
    check("busy", busy, rst && m_phase != 0);
    if (!rst) begin
      check("rst_sa_a", sa_a, 0);
      check("rst_sa_b", sa_b, 0);
      check("rst_rsp_c", rsp_c, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_err", rsp_err, 0);
    end else if (m_phase == 1) begin
      check("sa_a", sa_a, m_a);
      check("sa_b", sa_b, m_b);
    end else if (m_phase == 2) begin
      check("rsp_id", rsp_id, m_owner);
      check("rsp_c", rsp_c, m_c);
      check("rsp_err", rsp_err, m_err);
    end
    // observed events
    if (rst && (req_valid & req_ready) != 2'b00) begin
      grant_log.push_back(req_ready[1]);
      last_req_hs = cyc;
    end
    if (rst && rsp_valid && rsp_ready) begin
      got = {rsp_id, rsp_err, rsp_c};
      rsp_log.push_back(got);
      last_rsp_hs = cyc;
      check("rsp_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("rsp_scoreboard", got, exp_q.pop_front());
    end
    if (active_sa2) begin
      if (act_run == 0 && had_run) gap_q.push_back(low_cnt);
      act_run++;
      low_cnt = 0;
    end else begin
      if (act_run > 0) begin
        run_len_q.push_back(act_run);
        had_run = 1'b1;
      end
      act_run = 0;
      low_cnt++;
    end
    // advance the model to the state after the coming edge
    if (!rst) begin
      m_phase = 0; m_last = 1'b1; m_owner = 1'b0; m_err = 1'b0;
      m_a = '0; m_b = '0; m_c = '0; m_run = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (req_valid != 2'b00) begin
          m_a = g ? req_a1 : req_a0;
          m_b = g ? req_b1 : req_b0;
          m_owner = g; m_last = g; m_run = 0; m_phase = 1;
        end
        1: begin
          m_run++;
          if (done_sa2) begin
            m_c = conv(m_a, m_b); m_err = 1'b0; m_phase = 2;
            exp_q.push_back({m_owner, m_err, m_c});
          end
`ifdef SA2_SCHED_WDT_EN
          else if (m_run == TO) begin
            m_c = '0; m_err = 1'b1; m_phase = 2;
            exp_q.push_back({m_owner, m_err, m_c});
          end
`endif
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    rsp_log.delete(); grant_log.delete(); run_len_q.delete(); gap_q.delete();
    had_run = 1'b0; low_cnt = 0;
  endtask

  task automatic send(input int k, input logic [127:0] a, input logic [71:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (k == 0) begin req_a0 = a; req_b0 = b; end
    else        begin req_a1 = a; req_b1 = b; end
    req_valid[k] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin ok = 1'b1; break; end
    end
    check("send_granted", ok, 1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] mk_a(input int base, input int step);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i * 8 +: 8] = 8'(base + i * step);
    return v;
  endfunction

  function automatic logic [71:0] mk_b(input int base, input int step);
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[i * 8 +: 8] = 8'(base + i * step);
    return v;
  endfunction

  // ---------------- directed tests ----------------
  initial begin : main
    logic [127:0] a_inc;
    logic [71:0]  b_inc;
    int n;
    bit ok;
    a_inc = mk_a(1, 1);
    b_inc = mk_b(1, 1);
    check("model_conv_pin", conv(a_inc, b_inc), 32'hA174EDC0);

    // reset state
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_active", active_sa2, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // both requesters valid for 4 tiles: alternating grants, 2-cycle gaps
    stub_len = 5; rsp_ready = 1'b1; clear_logs();
    req_a0 = mk_a(3, 5); req_b0 = mk_b(1, 2);
    req_a1 = mk_a(255, -7); req_b1 = mk_b(100, 1);
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) n++;
    end
    check("rr_four_grants", n, 4);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
    check("rr_grant_cnt", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), grant_log[i], i % 2);
    check("rr_rsp_cnt", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_rsp_id%0d", i), rsp_log[i][33], i % 2);
    for (int i = 0; i < 4; i++) check($sformatf("rr_run_len%0d", i), run_len_q[i], 5);
    check("rr_gap_cnt", gap_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("rr_gap%0d", i), gap_q[i], 2);

    // real-array vector: a = 1..16, b = 1..9
    stub_len = 9; clear_logs();
    send(0, a_inc, b_inc);
    wait_idle();
    check("vec_rsp_cnt", rsp_log.size(), 1);
    check("vec_rsp", rsp_log[0], {1'b0, 1'b0, 32'hA174EDC0});
    check("vec_run_len", run_len_q[0], 9);

    // backpressure: response held 10 cycles, stray done and requester 1 waiting
    stub_len = 3; rsp_ready = 1'b0; clear_logs();
    send(0, mk_a(9, 3), mk_b(2, 5));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    check("bp_rsp_seen", ok, 1);
    @(posedge clk); #1;
    req_a1 = mk_a(40, 11); req_b1 = mk_b(7, 13);
    req_valid[1] = 1'b1; stray_done = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1; stray_done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[1]) begin ok = 1'b1; break; end
    end
    check("bp_next_grant", ok, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("bp_grant_delay", last_req_hs - last_rsp_hs, 1);
    check("bp_first_rsp", rsp_log[0], {1'b0, 1'b0, conv(mk_a(9, 3), mk_b(2, 5))});
    wait_idle();
    check("bp_second_rsp_id", rsp_log[1][33], 1);

    // requester 1 pulses while busy and drops: never granted
    stub_len = 4; clear_logs();
    send(0, mk_a(17, 2), mk_b(3, 3));
    req_a1 = mk_a(77, 1); req_b1 = mk_b(8, 8);
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk); #1;
    check("pulse_grant_cnt", grant_log.size(), 1);
    check("pulse_rsp_cnt", rsp_log.size(), 1);
    check("pulse_rsp_id", rsp_log[0][33], 0);

    // single-cycle run
    stub_len = 1; clear_logs();
    send(1, mk_a(200, 9), mk_b(31, 4));
    wait_idle();
    check("one_cyc_run_len", run_len_q[0], 1);
    check("one_cyc_rsp", rsp_log[0], {1'b1, 1'b0, conv(mk_a(200, 9), mk_b(31, 4))});

    // reset three cycles into RUN
    stub_len = 20; clear_logs();
    send(0, mk_a(5, 6), mk_b(1, 1));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    req_a0 = mk_a(60, 1); req_b0 = mk_b(2, 2);
    req_a1 = mk_a(90, 2); req_b1 = mk_b(4, 4);
    req_valid = 2'b11;
    #1;
    check("arst_active", active_sa2, 0);
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_req_ready", req_ready, 0);
    check("arst_sa_a", sa_a, 0);
    check("arst_sa_b", sa_b, 0);
    check("arst_rsp_c", rsp_c, 0);
    repeat (2) @(posedge clk); #1;
    clear_logs(); stub_len = 4;
    rst = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin ok = 1'b1; break; end
    end
    check("arst_regrant", ok, 1);
    check("arst_first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
    repeat (3) @(posedge clk); #1;
    check("arst_rsp_cnt", rsp_log.size(), 1);
    check("arst_rsp", rsp_log[0], {1'b0, 1'b0, conv(mk_a(60, 1), mk_b(2, 2))});

`ifdef SA2_SCHED_WDT_EN
    // watchdog expiry, then done on exactly the last allowed cycle
    stub_len = 0; clear_logs();
    send(0, mk_a(11, 1), mk_b(5, 1));
    wait_idle();
    check("wdt_run_len", run_len_q[0], TO);
    check("wdt_err_rsp", rsp_log[0], {1'b0, 1'b1, 32'h0});
    stub_len = TO; clear_logs();
    send(1, mk_a(12, 3), mk_b(6, 2));
    wait_idle();
    check("wdt_edge_run_len", run_len_q[0], TO);
    check("wdt_edge_rsp", rsp_log[0], {1'b1, 1'b0, conv(mk_a(12, 3), mk_b(6, 2))});
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sa2_conv_sched.md
# sa2_conv_sched

Scheduler that shares one `systolic_array_2_by_2` convolution engine (4x4 8-bit input tile, 3x3 8-bit kernel, 2x2 8-bit result) between two requesters.

- Arbitrates round-robin between the requesters.
- Latches the winner's operands and drives the array's `active_sa2` for the whole run.
- Captures `c11..c22` on `done_sa2` and returns them through a valid/ready response channel tagged with the requester ID.
- Sits between the layer-level tile fetchers and the array instance.

## Interface
Parameters:
- `DATA_W`, 8, operand/result element width.
- `TIMEOUT`, 64, max `active_sa2` cycles before abort (watchdog build only).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 2: bit k = requester k has a tile.
- `req_ready` out 2: bit k = tile accepted this cycle.
- `req_a0`, `req_a1` in 16*DATA_W: 4x4 tiles, row-major; a11 in [DATA_W-1:0], a44 in the MSBs.
- `req_b0`, `req_b1` in 9*DATA_W: 3x3 kernels, row-major, same packing.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_c` out 4*DATA_W: {c22,c21,c12,c11}, c11 in the LSBs.
- `rsp_err` out 1: watchdog abort; `rsp_c` = 0 when set.
- `active_sa2` out 1: run enable to the array.
- `sa_a` out 16*DATA_W: operands to the array.
- `sa_b` out 9*DATA_W: operands to the array.
- `done_sa2` in 1: array completion.
- `sa_c` in 4*DATA_W: array results.
- `busy` out 1: state != IDLE.

## Operation
States:
- IDLE → RUN on a request handshake.
- RUN → RESP on `done_sa2`=1, or on watchdog expiry.
- RESP → IDLE on `rsp_ready`=1.

Arbitration:
- Combinational, in IDLE only.
- One requester valid: it is granted.
- Both valid: the one not served last is granted. The `last` pointer resets to 1, so requester 0 wins first.
- `req_ready[k]` = IDLE && grant==k. It is one-hot or zero, and zero outside IDLE.

Handshake (IDLE, `req_valid[k] & req_ready[k]`):
- Latch `req_ak` / `req_bk` into operand registers.
- Store k as owner and update `last` to k.

RUN:
- `active_sa2`=1.
- `sa_a` / `sa_b` come from the operand registers and are stable for the whole run.
- Requester inputs are ignored.

Completion:
- On the first RUN cycle where `done_sa2`=1, capture `sa_c` into the result register and go to RESP.
- `done_sa2` is ignored outside RUN.

RESP:
- `active_sa2`=0; `rsp_valid`=1.
- `rsp_id`, `rsp_c` and `rsp_err` are held stable until `rsp_ready`.
- Handshake → IDLE.
- There are always ≥1 cycles with `active_sa2` low between runs, so the array re-arms.

Reset (asserted at any time, including mid-RUN):
- State IDLE, `last`=1, operand/result registers 0.
- All outputs 0: `active_sa2`, `req_ready`, `rsp_valid`, `rsp_id`, `rsp_c`, `rsp_err`, `sa_a`, `sa_b`, `busy`.
- An in-flight tile is dropped and no response is produced.

A requester may drop `req_valid` before it is granted; nothing is latched in that case.

## Timing
- Cycle N (IDLE): handshake.
- N+1: RUN, `active_sa2`=1.
- `done_sa2` sampled high at edge M: `rsp_valid`=1 and `active_sa2`=0 from M+1.
- If `rsp_ready` is already high, the response handshake occurs at M+1 and the scheduler is in IDLE at M+2. The next grant is possible at M+2.
- Latency from request handshake to `rsp_valid` = run length + 1 cycles.
- Throughput: one tile per (run length + 2) cycles with no backpressure.
- `done_sa2` high on the first RUN cycle: 1-cycle run, legal.

## Configuration
- `SA2_SCHED_WDT_EN` defined:
  - A counter clears on RUN entry and increments each RUN cycle.
  - If it reaches `TIMEOUT` with no `done_sa2`, go to RESP with `rsp_err`=1 and `rsp_c`=0.
  - If `done_sa2` arrives in the same cycle as expiry, `done_sa2` wins: `rsp_err`=0.
- Undefined:
  - No counter; RUN waits indefinitely.
  - `rsp_err` is tied 0 and `TIMEOUT` is unused.

## Test plan
- Real array, requester 0 with a=1..16 and b=1..9, `rsp_ready`=1 → `rsp_c` c11=192, c12=237, c21=116, c22=161, `rsp_id`=0, `rsp_err`=0. `active_sa2` is continuous from the cycle after the handshake until the cycle after `done_sa2`.
- Both requesters valid continuously for 4 tiles, stub array with `done_sa2` after 5 cycles → grants 0,1,0,1. Each `rsp_id` matches its grant, and `active_sa2` has a 2-cycle low gap between runs.
- `rsp_ready` held low for 10 cycles in RESP → `rsp_valid`, `rsp_c` and `rsp_id` stable; `req_ready`=0; `active_sa2`=0; no new grant until 1 cycle after the response handshake.
- Reset asserted 3 cycles into RUN → all outputs 0 immediately (async). After release, requester 0 wins the first grant and no stale response appears.
- `SA2_SCHED_WDT_EN`, `TIMEOUT`=8, stub never asserts `done_sa2` → `rsp_valid` at RUN+8 with `rsp_err`=1 and `rsp_c`=0. A second run with `done_sa2` on exactly cycle 8 → `rsp_err`=0.
- `req_valid[1]` pulsed for 1 cycle while busy, then dropped → never granted, no response for id 1.
